// File: rtl/multicycle_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm_if
// Bundle between the multi-cycle control unit and the datapath it steers.
//
// Parameters
//   FUNC_W      instruction function-field width
//   ALUOP_W     ALU operation code width
//   STACK_DEPTH return-stack entries (power of two, >= 2)
//
// Signals into the control unit (driven by instruction register / datapath)
//   inst_type, inst_function, stop_bit, zero_flag, mem_ready
// Signals out of the control unit
//   state, ALUop, PCsrc, ExSrc, ExS, RS2src, ALUsrc, WB, WBdata, MemR, MemW,
//   StR, StW, PCaddSrc1, PCaddSrc2, pc_we, ir_we, sp, stk_err
//
// Modports
//   master : the control unit
//   slave  : the datapath / instruction-register side
// ---------------------------------------------------------------------------
interface multicycle_ctrl_fsm_if #(
    parameter int FUNC_W      = 5,
    parameter int ALUOP_W     = 3,
    parameter int STACK_DEPTH = 8
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    // Instruction fields and datapath status
    logic [1:0]         inst_type;
    logic [FUNC_W-1:0]  inst_function;
    logic               stop_bit;
    logic               zero_flag;
    logic               mem_ready;

    // Control outputs
    logic [2:0]         state;
    logic [ALUOP_W-1:0] ALUop;
    logic [1:0]         PCsrc;
    logic [1:0]         ExSrc;
    logic               ExS;
    logic               RS2src;
    logic               ALUsrc;
    logic               WB;
    logic               WBdata;
    logic               MemR;
    logic               MemW;
    logic               StR;
    logic               StW;
    logic               PCaddSrc1;
    logic               PCaddSrc2;
    logic               pc_we;
    logic               ir_we;
    logic [SP_W-1:0]    sp;
    logic               stk_err;

    modport master (
        input  inst_type, inst_function, stop_bit, zero_flag, mem_ready,
        output state, ALUop, PCsrc, ExSrc, ExS, RS2src, ALUsrc, WB, WBdata,
               MemR, MemW, StR, StW, PCaddSrc1, PCaddSrc2, pc_we, ir_we,
               sp, stk_err
    );

    modport slave (
        output inst_type, inst_function, stop_bit, zero_flag, mem_ready,
        input  state, ALUop, PCsrc, ExSrc, ExS, RS2src, ALUsrc, WB, WBdata,
               MemR, MemW, StR, StW, PCaddSrc1, PCaddSrc2, pc_we, ir_we,
               sp, stk_err
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Multi-cycle control unit: owns the instruction-sequencing FSM
// (FETCH/DECODE/EXEC/MEM/WB/HALT), latches the instruction fields at the end
// of FETCH, drives every datapath control line from the registered state and
// latched fields, and tracks return-stack occupancy with a sticky
// overflow/underflow flag that parks the machine in HALT.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    multicycle_ctrl_fsm_if.master (instruction fields in, controls out)
//
// Optional feature macro: CU_MEM_WAIT_EN
//   defined   : MEM holds until mem_ready=1 (MemR/MemW held meanwhile)
//   undefined : MEM lasts exactly one cycle, mem_ready ignored
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int FUNC_W      = 5,
    parameter int ALUOP_W     = 3,
    parameter int STACK_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_ctrl_fsm_if.master bus
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2);

    localparam logic [1:0] PC_SEQ   = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_JUMP  = 2'b10;
    localparam logic [1:0] PC_STACK = 2'b11;

    localparam logic [SP_W-1:0] SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_EMPTY = SP_W'(0);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    // Registered state
    state_t            r_state;
    logic [1:0]        r_type;
    logic [FUNC_W-1:0] r_func;
    logic              r_stop;
    logic [SP_W-1:0]   r_sp;
    logic              r_stk_err;

    // Decoded instruction class
    logic w_is_ralu, w_is_cmp, w_is_andi, w_is_addi, w_is_lw, w_is_sw, w_is_beq;
    logic w_is_jmp, w_is_call, w_is_ret, w_is_push, w_is_pop;
    logic w_is_j, w_legal, w_uses_mem;
    logic [ALUOP_W-1:0] w_alu_code;

    // Sequencing / control
    state_t            w_next;
    logic              w_mem_done;
    logic              w_complete, w_push, w_pop, w_stop_ret, w_fault;
    logic [1:0]        w_pcsel;
    logic [SP_W-1:0]   w_sp_next;
    logic              w_err_set;
    logic              w_ir_we, w_pc_we, w_memr, w_memw, w_wb, w_wbdata;
    logic              w_str, w_stw, w_pcadd1, w_pcadd2;
    logic [1:0]        w_pcsrc;
    logic              w_exs, w_rs2src, w_alusrc;
    logic [ALUOP_W-1:0] w_aluop;
    logic [1:0]        w_exsrc;

`ifdef CU_MEM_WAIT_EN
    assign w_mem_done = bus.mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = bus.mem_ready;
    assign w_mem_done         = 1'b1;
`endif

    // Instruction-class decode from the latched type/function fields
    always_comb begin
        w_is_ralu = 1'b0;
        w_is_cmp  = 1'b0;
        w_is_andi = 1'b0;
        w_is_addi = 1'b0;
        w_is_lw   = 1'b0;
        w_is_sw   = 1'b0;
        w_is_beq  = 1'b0;
        w_is_jmp  = 1'b0;
        w_is_call = 1'b0;
        w_is_ret  = 1'b0;
        w_is_push = 1'b0;
        w_is_pop  = 1'b0;
        case (r_type)
            2'b00: begin
                case (r_func)
                    FUNC_W'(0), FUNC_W'(1), FUNC_W'(2): w_is_ralu = 1'b1;
                    FUNC_W'(3):                         w_is_cmp  = 1'b1;
                    default:                            w_is_ralu = 1'b0;
                endcase
            end
            2'b01: begin
                case (r_func)
                    FUNC_W'(0): w_is_andi = 1'b1;
                    FUNC_W'(1): w_is_addi = 1'b1;
                    FUNC_W'(2): w_is_lw   = 1'b1;
                    FUNC_W'(3): w_is_sw   = 1'b1;
                    FUNC_W'(4): w_is_beq  = 1'b1;
                    default:    w_is_andi = 1'b0;
                endcase
            end
            2'b10: begin
                case (r_func)
                    FUNC_W'(0): w_is_jmp  = 1'b1;
                    FUNC_W'(1): w_is_call = 1'b1;
                    FUNC_W'(2): w_is_ret  = 1'b1;
                    default:    w_is_jmp  = 1'b0;
                endcase
            end
            2'b11: begin
                case (r_func)
                    FUNC_W'(0): w_is_push = 1'b1;
                    FUNC_W'(1): w_is_pop  = 1'b1;
                    default:    w_is_push = 1'b0;
                endcase
            end
            default: w_is_ralu = 1'b0;
        endcase
    end

    assign w_is_j     = w_is_jmp | w_is_call | w_is_ret;
    assign w_uses_mem = w_is_lw | w_is_sw | w_is_push | w_is_pop;
    assign w_legal    = w_is_ralu | w_is_cmp | w_is_andi | w_is_addi | w_is_lw |
                        w_is_sw | w_is_beq | w_is_j | w_is_push | w_is_pop;

    // ALU operation: loads/stores form their address with ADD, CMP and BEQ compare with SUB
    always_comb begin
        w_alu_code = ALU_AND;
        if (w_is_cmp || w_is_beq || (w_is_ralu && (r_func == FUNC_W'(2)))) begin
            w_alu_code = ALU_SUB;
        end else if (w_is_addi || w_is_lw || w_is_sw || (w_is_ralu && (r_func == FUNC_W'(1)))) begin
            w_alu_code = ALU_ADD;
        end else begin
            w_alu_code = ALU_AND;
        end
    end

    // Operand/extender selects, held steady from DECODE to the end of the instruction
    always_comb begin
        w_exs     = 1'b0;
        w_rs2src  = 1'b0;
        w_alusrc  = 1'b0;
        w_aluop   = ALU_AND;
        w_exsrc   = 2'b00;
        if ((r_state == S_DECODE) || (r_state == S_EXEC) ||
            (r_state == S_MEM) || (r_state == S_WB)) begin
            w_exs    = w_is_addi | w_is_lw | w_is_sw | w_is_beq;
            w_rs2src = w_is_sw | w_is_beq;
            w_alusrc = (r_type == 2'b01);
            w_aluop  = w_alu_code;
            // the immediate sits in a different field for each class
            w_exsrc  = r_type;
        end else begin
            w_exs    = 1'b0;
        end
    end

    // Next state, stack bookkeeping and strobes for the current state
    always_comb begin
        w_next     = r_state;
        w_complete = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_ir_we    = 1'b0;
        w_memr     = 1'b0;
        w_memw     = 1'b0;
        w_wb       = 1'b0;
        w_wbdata   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_we = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                if (!w_legal) begin
                    w_next = S_HALT;
                end else if (w_is_j) begin
                    w_complete = 1'b1;
                    w_push     = w_is_call;
                    w_pop      = w_is_ret;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_is_beq || w_is_cmp) begin
                    w_complete = 1'b1;
                end else if (w_uses_mem) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_memr = w_is_lw;
                w_memw = w_is_sw;
                // stack access and exit only happen on the cycle memory reports done
                if (w_mem_done) begin
                    w_push = w_is_push;
                    w_pop  = w_is_pop;
                    if (w_is_lw || w_is_pop) begin
                        w_next = S_WB;
                    end else begin
                        w_complete = 1'b1;
                    end
                end else begin
                    w_next = S_MEM;
                end
            end
            S_WB: begin
                w_wb       = 1'b1;
                w_wbdata   = w_is_lw;
                w_complete = 1'b1;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_HALT;
            end
        endcase

        // stop_bit returns from the routine on completion; a push in the same
        // cycle (PUSH) wins, and J-type instructions never take the stop path
        w_stop_ret = w_complete & r_stop & ~w_is_j;
        if (w_stop_ret && !w_push) begin
            w_pop = 1'b1;
        end else begin
            w_pop = w_pop;
        end

        if (w_stop_ret) begin
            w_pcsel = PC_STACK;
        end else if (w_is_beq) begin
            w_pcsel = bus.zero_flag ? PC_IMM : PC_SEQ;
        end else if (w_is_jmp || w_is_call) begin
            w_pcsel = PC_JUMP;
        end else if (w_is_ret) begin
            w_pcsel = PC_STACK;
        end else begin
            w_pcsel = PC_SEQ;
        end

        w_fault = (w_push && (r_sp == SP_FULL)) || (w_pop && (r_sp == SP_EMPTY));

        // a faulting stack access suppresses every effect of the cycle
        if (w_fault) begin
            w_stw     = 1'b0;
            w_str     = 1'b0;
            w_pc_we   = 1'b0;
            w_pcsrc   = PC_SEQ;
            w_err_set = 1'b1;
            w_sp_next = r_sp;
            w_next    = S_HALT;
        end else begin
            w_stw     = w_push;
            w_str     = w_pop;
            w_pc_we   = w_complete;
            w_pcsrc   = w_complete ? w_pcsel : PC_SEQ;
            w_err_set = 1'b0;
            if (w_push) begin
                w_sp_next = r_sp + SP_W'(1);
            end else if (w_pop) begin
                w_sp_next = r_sp - SP_W'(1);
            end else begin
                w_sp_next = r_sp;
            end
            if (w_complete) begin
                w_next = S_FETCH;
            end else begin
                w_next = w_next;
            end
        end

        // PC adder operand selects: PC routed for the CALL return address,
        // immediate offset for a taken branch
        w_pcadd1 = w_stw & w_is_call;
        w_pcadd2 = w_pc_we & (w_pcsrc == PC_IMM);
    end

    // State, latched instruction fields, stack pointer and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_type    <= 2'b00;
            r_func    <= FUNC_W'(0);
            r_stop    <= 1'b0;
            r_sp      <= SP_EMPTY;
            r_stk_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sp    <= w_sp_next;
            if (w_ir_we) begin
                r_type <= bus.inst_type;
                r_func <= bus.inst_function;
                r_stop <= bus.stop_bit;
            end
            if (w_err_set) begin
                r_stk_err <= 1'b1;
            end
        end
    end

    assign bus.state     = r_state;
    assign bus.ALUop     = w_aluop;
    assign bus.PCsrc     = w_pcsrc;
    assign bus.ExSrc     = w_exsrc;
    assign bus.ExS       = w_exs;
    assign bus.RS2src    = w_rs2src;
    assign bus.ALUsrc    = w_alusrc;
    assign bus.WB        = w_wb;
    assign bus.WBdata    = w_wbdata;
    assign bus.MemR      = w_memr;
    assign bus.MemW      = w_memw;
    assign bus.StR       = w_str;
    assign bus.StW       = w_stw;
    assign bus.PCaddSrc1 = w_pcadd1;
    assign bus.PCaddSrc2 = w_pcadd2;
    assign bus.pc_we     = w_pc_we;
    assign bus.ir_we     = w_ir_we;
    assign bus.sp        = r_sp;
    assign bus.stk_err   = r_stk_err;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;
    localparam int DEPTH = 8;
`ifdef CU_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.FUNC_W(5), .ALUOP_W(3), .STACK_DEPTH(DEPTH)) bus ();

    multicycle_ctrl_fsm #(.FUNC_W(5), .ALUOP_W(3), .STACK_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // strobe vector order: ExS RS2src ALUsrc WB WBdata MemR MemW StR StW
    typedef struct {
        logic [2:0] st;
        logic       pcwe;
        logic       irwe;
        logic [1:0] pcsrc;
        logic [8:0] stb;
        logic [8:0] care;
        logic [2:0] aluop;
        logic       alu_care;
        logic [3:0] sp;
        logic       err;
    } exp_t;

    typedef enum {K_RALU, K_CMP, K_IALU, K_LW, K_SW, K_BEQ,
                  K_JMP, K_CALL, K_RET, K_PUSH, K_POP, K_ILL} kind_e;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   m_sp = 0;
    logic m_err = 1'b0;
    logic m_halt = 1'b0;
    logic m_stp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t rec(input logic [2:0] st);
        exp_t r;
        r.st       = st;
        r.pcwe     = 1'b0;
        r.irwe     = (st == 3'd0);
        r.pcsrc    = 2'b00;
        r.stb      = 9'd0;
        r.care     = ((st == 3'd2) || (st == 3'd7)) ? 9'h1FF : 9'h03F;
        r.aluop    = 3'd0;
        r.alu_care = 1'b0;
        r.sp       = 4'(m_sp);
        r.err      = m_err;
        return r;
    endfunction

    function automatic kind_e classify(input logic [1:0] t, input logic [4:0] f);
        case (t)
            2'b00: return (f <= 5'd2) ? K_RALU : ((f == 5'd3) ? K_CMP : K_ILL);
            2'b01: case (f)
                       5'd0, 5'd1: return K_IALU;
                       5'd2: return K_LW;
                       5'd3: return K_SW;
                       5'd4: return K_BEQ;
                       default: return K_ILL;
                   endcase
            2'b10: case (f)
                       5'd0: return K_JMP;
                       5'd1: return K_CALL;
                       5'd2: return K_RET;
                       default: return K_ILL;
                   endcase
            default: case (f)
                       5'd0: return K_PUSH;
                       5'd1: return K_POP;
                       default: return K_ILL;
                   endcase
        endcase
    endfunction

    // push a stack-touching or completing cycle; a full push / empty pop faults
    task automatic finalize(input exp_t r, input logic is_end, input logic [1:0] pcs,
                            input logic psh, input logic pp);
        if ((psh && m_sp == DEPTH) || (pp && m_sp == 0)) begin
            sbq.push_back(r);
            m_err  = 1'b1;
            m_halt = 1'b1;
        end else begin
            r.stb[0] = psh;
            r.stb[1] = pp;
            if (is_end) begin
                r.pcwe  = 1'b1;
                r.pcsrc = pcs;
            end
            sbq.push_back(r);
            m_sp = m_sp + int'(psh) - int'(pp);
        end
    endtask

    task automatic end_instr(input exp_t r, input logic [1:0] pcs, input logic psh);
        if (m_stp) finalize(r, 1'b1, 2'b11, psh, !psh);
        else       finalize(r, 1'b1, pcs, psh, 1'b0);
    endtask

    task automatic issue(input string nm, input logic [1:0] t, input logic [4:0] f,
                         input logic stp, input logic z, input int mlow);
        kind_e k;
        exp_t  r;
        logic [2:0] aop;
        logic  acare;
        int    nmem;
        int    low;
        exp_t  e;
        k = classify(t, f);
        m_stp = stp;
        bus.inst_type = t;
        bus.inst_function = f;
        bus.stop_bit = stp;
        bus.zero_flag = z;
        acare = (k == K_RALU || k == K_CMP || k == K_IALU || k == K_BEQ);
        aop = (k == K_CMP || k == K_BEQ) ? 3'd2 : ((k == K_RALU || k == K_IALU) ? f[2:0] : 3'd0);
        sbq.push_back(rec(3'd0));
        if (k == K_ILL) begin
            sbq.push_back(rec(3'd1));
            m_halt = 1'b1;
        end else if (k == K_JMP || k == K_CALL || k == K_RET) begin
            finalize(rec(3'd1), 1'b1, (k == K_RET) ? 2'b11 : 2'b10, k == K_CALL, k == K_RET);
        end else begin
            sbq.push_back(rec(3'd1));
            r = rec(3'd2);
            r.stb[8] = (k == K_IALU && f == 5'd1) || k == K_LW || k == K_SW || k == K_BEQ;
            r.stb[7] = (k == K_SW || k == K_BEQ);
            r.stb[6] = (k == K_IALU || k == K_LW || k == K_SW || k == K_BEQ);
            r.aluop = aop;
            r.alu_care = acare;
            if (k == K_BEQ || k == K_CMP) begin
                end_instr(r, (k == K_BEQ && z) ? 2'b01 : 2'b00, 1'b0);
            end else begin
                sbq.push_back(r);
                if (k == K_LW || k == K_SW || k == K_PUSH || k == K_POP) begin
                    nmem = WAIT_EN ? 1 + mlow : 1;
                    for (int i = 0; i < nmem; i++) begin
                        r = rec(3'd3);
                        r.stb[3] = (k == K_LW);
                        r.stb[2] = (k == K_SW);
                        if (i < nmem - 1) sbq.push_back(r);
                        else if (k == K_SW || k == K_PUSH) end_instr(r, 2'b00, k == K_PUSH);
                        else finalize(r, 1'b0, 2'b00, 1'b0, k == K_POP);
                    end
                end
                if (!m_halt && (k == K_RALU || k == K_IALU || k == K_LW || k == K_POP)) begin
                    r = rec(3'd4);
                    r.stb[5] = 1'b1;
                    r.stb[4] = (k == K_LW);
                    r.aluop = aop;
                    r.alu_care = acare;
                    end_instr(r, 2'b00, 1'b0);
                end
            end
        end
        if (m_halt) begin
            for (int i = 0; i < 3; i++) sbq.push_back(rec(3'd7));
        end
        low = mlow;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.st == 3'd3 && low > 0) begin
                bus.mem_ready = 1'b0;
                low--;
            end else begin
                bus.mem_ready = 1'b1;
            end
            @(negedge clk);
            chk({nm, ".state"}, 32'(bus.state), 32'(e.st));
            chk({nm, ".pc_we"}, 32'(bus.pc_we), 32'(e.pcwe));
            chk({nm, ".ir_we"}, 32'(bus.ir_we), 32'(e.irwe));
            chk({nm, ".PCsrc"}, 32'(bus.PCsrc), 32'(e.pcsrc));
            chk({nm, ".strobes"}, 32'({bus.ExS, bus.RS2src, bus.ALUsrc, bus.WB, bus.WBdata,
                                       bus.MemR, bus.MemW, bus.StR, bus.StW} & e.care),
                32'(e.stb & e.care));
            if (e.alu_care) chk({nm, ".ALUop"}, 32'(bus.ALUop), 32'(e.aluop));
            chk({nm, ".sp"}, 32'(bus.sp), 32'(e.sp));
            chk({nm, ".stk_err"}, 32'(bus.stk_err), 32'(e.err));
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b1;
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        m_sp = 0;
        m_err = 1'b0;
        m_halt = 1'b0;
        @(negedge clk);
        chk({nm, ".state"}, 32'(bus.state), 32'd0);
        chk({nm, ".sp"}, 32'(bus.sp), 32'd0);
        chk({nm, ".stk_err"}, 32'(bus.stk_err), 32'd0);
        chk({nm, ".PCsrc"}, 32'(bus.PCsrc), 32'd0);
        chk({nm, ".ALUop"}, 32'(bus.ALUop), 32'd0);
        chk({nm, ".strobes"}, 32'({bus.ExS, bus.RS2src, bus.ALUsrc, bus.WB, bus.WBdata,
                                   bus.MemR, bus.MemW, bus.StR, bus.StW, bus.pc_we,
                                   bus.PCaddSrc1, bus.PCaddSrc2}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.inst_type = 2'b00;
        bus.inst_function = 5'd0;
        bus.stop_bit = 1'b0;
        bus.zero_flag = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset("reset");

        issue("add",   2'b00, 5'd1, 1'b0, 1'b0, 0);
        issue("lw",    2'b01, 5'd2, 1'b0, 1'b0, 3);
        issue("beq_t", 2'b01, 5'd4, 1'b0, 1'b1, 0);
        issue("beq_n", 2'b01, 5'd4, 1'b0, 1'b0, 0);
        issue("sw",    2'b01, 5'd3, 1'b0, 1'b0, 0);
        issue("sub",   2'b00, 5'd2, 1'b0, 1'b1, 0);
        issue("cmp",   2'b00, 5'd3, 1'b0, 1'b0, 0);
        issue("jmp",   2'b10, 5'd0, 1'b0, 1'b0, 0);
        issue("push",  2'b11, 5'd0, 1'b0, 1'b0, 0);
        issue("pop",   2'b11, 5'd1, 1'b0, 1'b0, 0);
        issue("andi",  2'b01, 5'd0, 1'b0, 1'b0, 0);

        issue("call",  2'b10, 5'd1, 1'b0, 1'b0, 0);
        issue("addi_stop", 2'b01, 5'd1, 1'b1, 1'b0, 0);
        issue("ret_under", 2'b10, 5'd2, 1'b0, 1'b0, 0);
        do_reset("reset_after_under");

        issue("illegal", 2'b10, 5'd7, 1'b0, 1'b0, 0);
        do_reset("reset_after_illegal");

        for (int i = 0; i < 9; i++) begin
            issue($sformatf("call%0d", i), 2'b10, 5'd1, 1'b1, 1'b0, 0);
        end
        do_reset("reset_after_over");
        issue("add_after", 2'b00, 5'd0, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Parametrised multi-cycle control unit for the processor datapath. It owns the instruction-sequencing state machine instead of taking the state as an input. It latches the decoded instruction fields and drives every datapath control line. It also keeps an internal return-address stack pointer with overflow/underflow detection, and sits between the instruction register and the datapath muxes, ALU, data memory and return stack.

## Interface
- FUNC_W, default 5: instruction function-field width
- ALUOP_W, default 3: ALU operation code width
- STACK_DEPTH, default 8: return-stack entries, power of two, at least 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- inst_type  in  2  instruction class: 00 R, 01 I, 10 J, 11 S
- inst_function  in  FUNC_W  function code
- stop_bit  in  1  instruction ends a called routine; return after completion
- zero_flag  in  1  ALU zero result
- mem_ready  in  1  data-memory done (used only with CU_MEM_WAIT_EN)
- state  out  3  current state: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 HALT
- ALUop  out  ALUOP_W  ALU op: 0 AND, 1 ADD, 2 SUB
- PCsrc  out  2  next-PC select: 00 PC+1, 01 PC+imm, 10 jump target, 11 stack top
- ExSrc  out  2  immediate extender field select
- ExS, RS2src, ALUsrc, WB, WBdata, MemR, MemW, StR, StW, PCaddSrc1, PCaddSrc2  out  1  each a datapath control strobe
- pc_we, ir_we  out  1  PC write enable; instruction-register load
- sp  out  $clog2(STACK_DEPTH)+1  stack occupancy
- stk_err  out  1  sticky stack overflow/underflow flag

## Operation
- Instruction fields are latched on the FETCH→DECODE edge, with ir_we=1 during FETCH. Control outputs are combinational from the registered state and the latched fields.
- Decode set:
  - R-type: AND=0, ADD=1, SUB=2, CMP=3. CMP uses SUB and has no writeback.
  - I-type: ANDI=0, ADDI=1, LW=2, SW=3, BEQ=4.
  - J-type: JMP=0, CALL=1, RET=2.
  - S-type: PUSH=0, POP=1.
- Any other code is illegal: HALT, with stk_err unchanged.
- State sequences:
  - R, ANDI, ADDI: F,D,E,WB.
  - LW: F,D,E,M,WB.
  - SW, PUSH: F,D,E,M.
  - POP: F,D,E,M,WB.
  - BEQ, CMP: F,D,E.
  - JMP, CALL, RET: F,D.
  - The last state of each sequence returns to FETCH with pc_we=1.
- PCsrc on the completing cycle:
  - BEQ: 01 if zero_flag else 00.
  - JMP and CALL: 10.
  - RET: 11.
  - All others: 00.
  - If stop_bit is latched on a non-J instruction: 11.
- Stack:
  - CALL asserts StW and increments sp.
  - RET, and any stop_bit completion, assert StR and decrement sp.
  - PUSH asserts StW and POP asserts StR in MEM, with the same sp update.
- Memory strobes:
  - LW: MemR in MEM; WBdata=1 in WB.
  - SW: MemW in MEM.
  - RS2src=1 for SW and BEQ.
  - ALUsrc=1 for I-type.
  - ExS=1 (sign-extend) for ADDI, LW, SW, BEQ.
- Push with sp==STACK_DEPTH, or pop with sp==0:
  - no sp change, no StW/StR, stk_err=1, state→HALT.
- HALT is terminal until reset. In HALT all strobes are 0 and pc_we=0.

## Timing
- Reset (asynchronous): state=FETCH, sp=0, stk_err=0, latched fields=0, PCsrc=00, ALUop=0, ExSrc=00, all 1-bit strobes 0.
- The first FETCH after reset release lasts one cycle and asserts ir_we.
- Latency per instruction equals its state count, from 2 (JMP) to 5 (LW) cycles, plus memory wait cycles when CU_MEM_WAIT_EN is defined.
- sp and stk_err update on the rising edge ending the asserting state.
- stop_bit on CALL is ignored: the push wins and no pop occurs.
- Reset asserted mid-instruction aborts it immediately. Pending stack updates are discarded.

## Configuration
- CU_MEM_WAIT_EN defined:
  - MEM holds while mem_ready=0.
  - MemR/MemW stay asserted throughout.
  - The MEM exit occurs on the edge where mem_ready=1.
- Undefined: MEM is exactly one cycle and mem_ready is ignored.

## Test plan
- Reset, then ADD (type 00, func 1): states 0,1,2,4,0 over 4 cycles; ALUop=1 and WB=1 in WB; pc_we=1 in WB; PCsrc=00.
- LW (01, func 2): MemR=1 in state 3; WBdata=1 in state 4; ExS=1 and ALUsrc=1 in EXEC. With CU_MEM_WAIT_EN and mem_ready held low 3 cycles, state 3 persists exactly 4 cycles.
- BEQ with zero_flag=1: PCsrc=01 in EXEC. BEQ with zero_flag=0: PCsrc=00. Both return to FETCH after 3 cycles.
- CALL nine times with STACK_DEPTH=8:
  - sp reaches 8.
  - The ninth CALL gives stk_err=1, state=7, sp stays 8, and StW=0.
  - state stays 7 until rst_n low.
- CALL then ADDI with stop_bit=1: ADDI completes with PCsrc=11 and StR=1, and sp goes 1→0. A subsequent RET gives underflow: stk_err=1 and HALT.
- Illegal code (type 10, func 7): HALT after DECODE; stk_err=0.
